// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: capture FSM state encoding, also used by
// the JTAG readout glue to decode state_o.
package la_pkg;

    localparam logic [2:0] LA_ST_IDLE = 3'd0;
    localparam logic [2:0] LA_ST_FILL = 3'd1;
    localparam logic [2:0] LA_ST_WAIT = 3'd2;
    localparam logic [2:0] LA_ST_POST = 3'd3;
    localparam logic [2:0] LA_ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = LA_ST_IDLE,
        ST_FILL = LA_ST_FILL,
        ST_WAIT = LA_ST_WAIT,
        ST_POST = LA_ST_POST,
        ST_DONE = LA_ST_DONE
    } la_state_e;

    // States in which the probe bus is being written into the buffer.
    function automatic logic la_capturing(input la_state_e st);
        return (st == ST_FILL) || (st == ST_WAIT) || (st == ST_POST);
    endfunction

endpackage

// File: rtl/la_ram.sv
// Sample buffer: single clock, one write port, one registered read port.
// Contents are deliberately unreset so this maps onto block RAM.
module la_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/la_capture.sv
// Logic-analyzer capture engine: circular pre-trigger history, masked
// level/edge trigger, post-trigger fill and trigger-relative readout.
module la_capture
    import la_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 64,
    parameter int PRE_TRIG = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] probe_i,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] trig_mask_i,
    input  logic [WIDTH-1:0] trig_value_i,
    input  logic             trig_edge_i,
    output logic [2:0]       state_o,
    output logic             done_o,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o
);

    localparam int POST_N = DEPTH - PRE_TRIG - 1;

    la_state_e        state;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    cnt;
    logic [AW-1:0]    trig_addr;
    logic             prev_match;
    logic             match;
    logic             trig;
    logic             fill_last;
    logic             post_last;
    logic             capturing;
    logic             rd_fire;
    logic [AW-1:0]    rd_phys;
    logic [WIDTH-1:0] ram_rdata;

    assign match     = ((probe_i ^ trig_value_i) & trig_mask_i) == '0;
    assign trig      = match && (!trig_edge_i || !prev_match);
    assign capturing = la_capturing(state);
    assign fill_last = (int'(cnt) + 1) >= PRE_TRIG;
    assign post_last = (int'(cnt) + 1) >= POST_N;
    assign rd_fire   = rd_en_i && (state == ST_DONE);
    // Oldest kept sample sits PRE_TRIG slots behind the trigger; AW-bit math wraps.
    assign rd_phys   = trig_addr - AW'(PRE_TRIG) + rd_addr_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            cnt        <= '0;
            trig_addr  <= '0;
            prev_match <= 1'b0;
            done_o     <= 1'b0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= 1'b0;
            prev_match <= match;
            if (capturing)
                wr_ptr <= wr_ptr + 1'b1;
            if (abort_i) begin
                state  <= ST_IDLE;
                done_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (arm_i) begin
                            state      <= ST_FILL;
                            wr_ptr     <= '0;
                            cnt        <= '0;
                            prev_match <= 1'b1;
                            done_o     <= 1'b0;
                        end else if (rd_fire) begin
                            rd_valid_o <= 1'b1;
                        end
                    end
                    ST_FILL: begin
                        cnt <= cnt + 1'b1;
                        if (fill_last) begin
                            state <= ST_WAIT;
                            cnt   <= '0;
                        end
                    end
                    ST_WAIT: begin
                        if (trig) begin
                            trig_addr <= wr_ptr;
                            cnt       <= '0;
                            if (POST_N == 0) begin
                                state  <= ST_DONE;
                                done_o <= 1'b1;
                            end else begin
                                state <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        cnt <= cnt + 1'b1;
                        if (post_last) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    la_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (capturing),
        .waddr (wr_ptr),
        .wdata (probe_i),
        .re    (rd_fire),
        .raddr (rd_phys),
        .rdata (ram_rdata)
    );

    // RAM output is unreset, so hold the port at zero unless a read is presented.
    assign rd_data_o = rd_valid_o ? ram_rdata : '0;
    assign state_o   = state;

endmodule

// File: tb/tb_la_capture.sv
// Directed self-checking bench for la_capture (WIDTH=16, DEPTH=64, PRE_TRIG=16).
module tb_la_capture;

    logic        clk;
    logic        rst_n;
    logic [15:0] probe_i;
    logic        arm_i;
    logic        abort_i;
    logic [15:0] trig_mask_i;
    logic [15:0] trig_value_i;
    logic        trig_edge_i;
    logic [2:0]  state_o;
    logic        done_o;
    logic        rd_en_i;
    logic [5:0]  rd_addr_i;
    logic [15:0] rd_data_o;
    logic        rd_valid_o;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] cnt;
    logic [15:0] p_or;
    logic [15:0] p_clr;

    la_capture #(.WIDTH(16), .DEPTH(64), .PRE_TRIG(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .probe_i      (probe_i),
        .arm_i        (arm_i),
        .abort_i      (abort_i),
        .trig_mask_i  (trig_mask_i),
        .trig_value_i (trig_value_i),
        .trig_edge_i  (trig_edge_i),
        .state_o      (state_o),
        .done_o       (done_o),
        .rd_en_i      (rd_en_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic set_probe();
        probe_i = (cnt | p_or) & ~p_clr;
    endtask

    // One rising edge; probe advances to the next count afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
        cnt = cnt + 16'd1;
        set_probe();
    endtask

    task automatic arm(input logic [15:0] mask, input logic [15:0] value, input logic edge_m);
        trig_mask_i  = mask;
        trig_value_i = value;
        trig_edge_i  = edge_m;
        cnt = 16'd0;
        set_probe();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (done_o) break;
            tick();
        end
    endtask

    task automatic rd(input logic [5:0] a);
        rd_en_i   = 1'b1;
        rd_addr_i = a;
        tick();
        rd_en_i   = 1'b0;
    endtask

    task automatic check_rd(input string name, input logic [15:0] exp);
        checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== exp) begin
            errors++;
            $display("FAIL %s: got valid=%b data=%h, want valid=1 data=%h", name, rd_valid_o, rd_data_o, exp);
        end
    endtask

    task automatic check_basic_capture(input string tag);
        wait_done(200);
        checks++;
        if (done_o !== 1'b1 || state_o !== 3'd4 || cnt !== 16'd96) begin
            errors++;
            $display("FAIL %s_done: done=%b state=%0d at count %0d, want done=1 state=4 at count 96", tag, done_o, state_o, cnt);
        end
        rd(6'd0);  check_rd({tag, "_rd0"},  16'h0020);
        rd(6'd16); check_rd({tag, "_rd16"}, 16'h0030);
        rd(6'd63); check_rd({tag, "_rd63"}, 16'h005F);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (state_o !== 3'd0 || done_o !== 1'b0 || rd_valid_o !== 1'b0 || rd_data_o !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: state=%0d done=%b valid=%b data=%h, want all 0", state_o, done_o, rd_valid_o, rd_data_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle: state=%0d, want 0", state_o);
        end
    endtask

    task automatic test_basic();
        arm(16'hFFFF, 16'h0030, 1'b0);
        checks++;
        if (state_o !== 3'd1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_arm: state=%0d done=%b, want state=1 done=0", state_o, done_o);
        end
        check_basic_capture("basic");
    endtask

    task automatic test_back_to_back();
        rd_en_i   = 1'b1;
        rd_addr_i = 6'd0;
        for (int i = 0; i < 64; i++) begin
            tick();
            check_rd("b2b", 16'h0020 + 16'(i));
            if (i == 63) rd_en_i = 1'b0;
            else         rd_addr_i = 6'(i + 1);
        end
        tick();
        checks++;
        if (rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: valid=%b, want 0", rd_valid_o);
        end
    endtask

    task automatic test_holdoff();
        p_or = 16'h0001;
        arm(16'h0001, 16'h0001, 1'b0);
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL holdoff_rearm_done: done=%b, want 0", done_o);
        end
        for (int i = 0; i < 16; i++) tick();
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL holdoff_wait: state=%0d after 16 samples, want 2", state_o);
        end
        tick();
        checks++;
        if (state_o !== 3'd3) begin
            errors++;
            $display("FAIL holdoff_trig17: state=%0d after 17th sample, want 3", state_o);
        end
        wait_done(200);
        rd(6'd0);  check_rd("holdoff_rd0",  16'h0001);
        rd(6'd16); check_rd("holdoff_rd16", 16'h0011);
        rd(6'd17); check_rd("holdoff_rd17", 16'h0013);
        p_or = 16'h0000;
    endtask

    task automatic test_edge();
        logic [15:0] drop_v;
        logic [15:0] ret_v;
        p_or = 16'h8000;
        arm(16'h8000, 16'h8000, 1'b1);
        for (int i = 0; i < 200; i++) tick();
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL edge_hold: state=%0d after 200 matching cycles, want 2", state_o);
        end
        p_clr = 16'h8000;
        set_probe();
        drop_v = probe_i;
        tick();
        p_clr = 16'h0000;
        set_probe();
        ret_v = probe_i;
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL edge_drop: state=%0d on drop cycle, want 2", state_o);
        end
        tick();
        checks++;
        if (state_o !== 3'd3) begin
            errors++;
            $display("FAIL edge_return: state=%0d after return cycle, want 3", state_o);
        end
        wait_done(200);
        rd(6'd16); check_rd("edge_rd16", ret_v);
        rd(6'd15); check_rd("edge_rd15", drop_v);
        p_or = 16'h0000;
    endtask

    task automatic test_abort();
        arm(16'hFFFF, 16'h0030, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (state_o == 3'd3) break;
            tick();
        end
        checks++;
        if (state_o !== 3'd3) begin
            errors++;
            $display("FAIL abort_reach_post: state=%0d, want 3", state_o);
        end
        for (int i = 0; i < 5; i++) tick();
        abort_i = 1'b1;
        arm_i   = 1'b1;
        tick();
        abort_i = 1'b0;
        arm_i   = 1'b0;
        checks++;
        if (state_o !== 3'd0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: state=%0d done=%b, want state=0 done=0", state_o, done_o);
        end
        rd(6'd0);
        checks++;
        if (rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_read: valid=%b, want 0", rd_valid_o);
        end
        for (int i = 0; i < 60; i++) tick();
        checks++;
        if (state_o !== 3'd0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_stays_idle: state=%0d done=%b, want 0 0", state_o, done_o);
        end
    endtask

    task automatic test_reset_mid();
        arm(16'hFFFF, 16'h0030, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL rstmid_wait: state=%0d, want 2", state_o);
        end
        rd_en_i = 1'b1;
        rst_n   = 1'b0;
        #1;
        checks++;
        if (state_o !== 3'd0 || done_o !== 1'b0 || rd_valid_o !== 1'b0 || rd_data_o !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: state=%0d done=%b valid=%b data=%h, want all 0", state_o, done_o, rd_valid_o, rd_data_o);
        end
        @(posedge clk); #1;
        rd_en_i = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i < 70; i++) tick();
        checks++;
        if (state_o !== 3'd0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_partial: state=%0d done=%b, want 0 0", state_o, done_o);
        end
        arm(16'hFFFF, 16'h0030, 1'b0);
        check_basic_capture("rstmid");
    endtask

    initial begin
        arm_i        = 1'b0;
        abort_i      = 1'b0;
        rd_en_i      = 1'b0;
        rd_addr_i    = 6'd0;
        trig_mask_i  = 16'h0;
        trig_value_i = 16'h0;
        trig_edge_i  = 1'b0;
        p_or         = 16'h0;
        p_clr        = 16'h0;
        cnt          = 16'h0;
        probe_i      = 16'h0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_holdoff();
        test_edge();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/la_capture.md
LA_CAPTURE -- requirements
Module: la_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning probe bus width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, meaning sample buffer depth; it must be a power of two and at least 4.
REQ-003 SHALL have parameter PRE_TRIG, default 16, meaning samples kept before the trigger; range 0..DEPTH-1.
REQ-004 SHALL use AW = log2(DEPTH) for address widths.
REQ-005 SHALL have ports as follows (name, direction, width, meaning):
- clk  in  1  single clock; all state is sampled on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- probe_i  in  WIDTH  signals to be sampled.
- arm_i  in  1  start a capture (one-cycle pulse).
- abort_i  in  1  cancel a capture (one-cycle pulse).
- trig_mask_i  in  WIDTH  bits that take part in the trigger compare.
- trig_value_i  in  WIDTH  required value of the masked bits.
- trig_edge_i  in  1  0 = level trigger, 1 = trigger on the rising edge of a match.
- state_o  out  3  current FSM state encoding.
- done_o  out  1  capture complete and buffer readable.
- rd_en_i  in  1  read request.
- rd_addr_i  in  AW  read address, where 0 is the oldest sample.
- rd_data_o  out  WIDTH  read data.
- rd_valid_o  out  1  rd_data_o is valid.

Function
REQ-006 SHALL implement states IDLE=0, FILL=1, WAIT=2, POST=3, DONE=4.
REQ-007 SHALL define match as ((probe_i ^ trig_value_i) & trig_mask_i) == 0.
REQ-008 SHALL fire the trigger on match in level mode, and on match with a registered previous match of 0 in edge mode.
REQ-009 SHALL, on arm_i in IDLE or DONE, go to FILL, clear the write pointer and sample count, set the previous-match register to 1 (so no false edge at arm), and deassert done_o.
REQ-010 SHALL ignore arm_i in FILL, WAIT and POST.
REQ-011 SHALL write probe_i into the buffer on every clk in FILL, WAIT and POST, with the write pointer wrapping modulo DEPTH.
REQ-012 SHALL ignore the trigger in FILL; FILL goes to WAIT once PRE_TRIG samples are stored, or on the first cycle when PRE_TRIG = 0.
REQ-013 SHALL, on a trigger in WAIT, record the trigger sample's write address and go to POST.
REQ-014 SHALL, in POST, store exactly DEPTH-PRE_TRIG-1 further samples, then go to DONE and stop writing.
REQ-015 SHALL, when DEPTH-PRE_TRIG-1 = 0, go from WAIT directly to DONE on the trigger cycle.
REQ-016 SHALL, in WAIT, keep overwriting the oldest samples until the trigger, so that pre-trigger history is always the most recent PRE_TRIG samples.
REQ-017 SHALL, in readout order, place the trigger sample at rd_addr = PRE_TRIG.
REQ-018 SHALL read physical address (trig_addr - PRE_TRIG + rd_addr_i) mod DEPTH.
REQ-019 SHALL, on rd_en_i in DONE, assert rd_valid_o and rd_data_o one cycle later (latency 1); rd_en_i in any other state produces rd_valid_o = 0.
REQ-020 SHALL support back-to-back reads at one sample per cycle.
REQ-021 SHALL, on abort_i in any state, return to IDLE on the next clk with done_o = 0; abort_i wins over a simultaneous arm_i or trigger.
REQ-022 SHALL treat trig_mask_i = 0 as always matching: a level trigger fires on the first WAIT cycle; an edge trigger never fires.
REQ-023 SHALL require trigger inputs to be static while not IDLE or DONE; changes during a capture take effect on the next compare.

Reset
REQ-024 SHALL, on rst_n low, immediately set state IDLE, done_o 0, rd_valid_o 0, rd_data_o 0, pointers and counters 0, and previous-match register 0.
REQ-025 SHALL leave buffer contents unreset so they map to block RAM.
REQ-026 SHALL abandon any capture or readout in progress when reset is asserted mid-operation, with no partial done.

Structure
REQ-027 SHALL put the state enum and its encoding constants in shared package la_pkg, which is also used by the JTAG readout glue.
REQ-028 SHALL implement storage as sub-module la_ram (single clock, one write port, one synchronous read port, parameters WIDTH and DEPTH).
REQ-029 SHALL keep the FSM, trigger compare and address arithmetic in la_capture.

Verification
All scenarios use WIDTH=16, DEPTH=64, PRE_TRIG=16, and probe_i = a free-running 16-bit count that is 0 on the arm cycle, unless stated.
REQ-030 SHALL cover a basic level trigger: mask 0xFFFF, value 0x0030 -> done_o rises after the last post-trigger sample; read addr 0 = 0x0020, addr 16 = 0x0030, addr 63 = 0x005F.
REQ-031 SHALL cover pre-trigger holdoff: mask 0x0001, value 1, probe bit0 held at 1 from arm -> trigger at the 17th sample, not the 1st; read addr 16 holds that sample.
REQ-032 SHALL cover edge mode: trig_edge_i = 1, probe constantly matching -> no trigger for 200 cycles; probe then drops for 1 cycle and returns -> trigger on the return cycle.
REQ-033 SHALL cover abort: abort_i pulsed in POST together with arm_i -> state_o = 0 next cycle, done_o = 0, rd_valid_o stays 0 on reads.
REQ-034 SHALL cover reset mid-capture: rst_n pulsed low in WAIT -> all outputs 0 within the reset; a fresh arm then gives a correct capture as in REQ-030.
REQ-035 SHALL cover back-to-back readout: rd_en_i held high for 64 cycles with addresses 0..63 -> 64 consecutive rd_valid_o cycles with data 0x0020..0x005F in order.
